ex_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for the execute stage. It consumes DIV/DIVU operands and control straight from the ID/EX pipeline register outputs. It raises a stall request while dividing and delivers quotient (LO) and remainder (HI) for the HILO write path. One quotient bit is resolved per cycle, and pipeline flushes cancel it cleanly.

---
 rtl/ex_divider_pkg.sv | 7 +
 rtl/ex_divider_step.sv | 18 +
 rtl/ex_divider.sv | 112 +++++++++++
 tb/tb_ex_divider.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_divider_pkg.sv
// ex_divider_pkg: shared execute-stage constants and types for the multi-cycle divider
package ex_divider_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [4:0] ALU_DIV  = 5'b10010;
    localparam logic [4:0] ALU_DIVU = 5'b10011;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/ex_divider_step.sv
// ex_divider_step: one restoring-division iteration (shift, compare, conditional subtract)
module ex_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);
    logic [WIDTH:0] rem_sh;
    logic           ge;
    assign rem_sh = {rem_i, dvd_i[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs_i};
    // the true difference is below the divisor, so it always fits in WIDTH bits
    assign rem_o  = ge ? rem_sh[WIDTH-1:0] - dvs_i : rem_sh[WIDTH-1:0];
    assign dvd_o  = {dvd_i[WIDTH-2:0], ge};
endmodule

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring DIV/DIVU unit for EX; stalls the pipe while busy,
// delivers quotient (LO) and remainder (HI) with a one-cycle done pulse.
module ex_divider
    import ex_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic [WIDTH-1:0] step_dvd, step_rem, q_fix, r_fix;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    ex_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q),
        .dvd_i(dvd_q),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .dvd_o(step_dvd)
    );

    // divide-by-zero leaves |opa| in the accumulator, so the remainder fix-up restores opa
    assign q_fix = dz_q ? '1 : (negq_q ? -step_dvd : step_dvd);
    assign r_fix = negr_q ? -step_rem : step_rem;

    assign stall_req = (state_q == IDLE && start && !cancel) || state_q == BUSY;
    assign done      = state_q == DONE && !cancel;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        if (cancel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = BUSY;
                    dvd_d   = (signed_div && opa[WIDTH-1]) ? -opa : opa;
                    dvs_d   = (signed_div && opb[WIDTH-1]) ? -opb : opb;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    negq_d  = signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    negr_d  = signed_div && opa[WIDTH-1];
                    dz_d    = opb == '0;
                end
                BUSY: begin
                    dvd_d = step_dvd;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        quo_d   = q_fix;
                        rmd_d   = r_fix;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end
endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed and randomized checks of ex_divider against an arithmetic reference
module tb_ex_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        cancel = 1'b0;
    logic        stall_req, done;
    logic [31:0] quotient, remainder;
    int          n_cmp = 0;
    int          n_fail = 0;

    ex_divider dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opa(opa), .opb(opb), .cancel(cancel), .stall_req(stall_req),
        .done(done), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // reference built from language-level division: returns {remainder, quotient}
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // runs one operation with start held until done; cycle 0 is the start cycle
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit b2b,
                          output int dcyc, output int nstall, output logic sdone,
                          output logic [31:0] q, output logic [31:0] r);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        signed_div = s;
        opa = a;
        opb = b;
        dcyc = -1;
        nstall = 0;
        sdone = 1'bx;
        q = '0;
        r = '0;
        for (int c = 0; c < 50 && dcyc < 0; c++) begin
            @(negedge clk);
            if (stall_req) nstall++;
            if (done) begin
                dcyc = c;
                sdone = stall_req;
                q = quotient;
                r = remainder;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                opa = $urandom;
                opb = $urandom;
                signed_div = 1'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({stall_req, done, quotient, remainder} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b done=%b q=%h r=%h, want all 0", stall_req, done, quotient, remainder);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_unsigned();
        int dc, ns;
        logic sd;
        logic [31:0] q, r;
        do_div(1'b0, 32'd100, 32'd7, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if (dc !== 33) begin n_fail++; $display("FAIL divu_latency: done at cycle %0d, want 33", dc); end
        n_cmp++;
        if (ns !== 33) begin n_fail++; $display("FAIL divu_stall_cycles: %0d stall cycles, want 33", ns); end
        n_cmp++;
        if (sd !== 1'b0) begin n_fail++; $display("FAIL divu_stall_at_done: got %b, want 0", sd); end
        n_cmp++;
        if ({q, r} !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL divu_100_7: got q=%0d r=%0d, want q=14 r=2", q, r); end
    endtask

    task automatic test_signed();
        int dc, ns;
        logic sd;
        logic [31:0] q, r;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL div_m7_2: got q=%h r=%h, want q=fffffffd r=ffffffff", q, r);
        end
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if ({q, r} !== {32'h8000_0000, 32'd0}) begin
            n_fail++; $display("FAIL div_wrap: got q=%h r=%h, want q=80000000 r=0", q, r);
        end
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if ({q, r} !== {32'hFFFF_FFFD, 32'd1}) begin
            n_fail++; $display("FAIL div_7_m2: got q=%h r=%h, want q=fffffffd r=1", q, r);
        end
    endtask

    task automatic test_div_zero();
        int dc, ns;
        logic sd;
        logic [31:0] q, r;
        do_div(1'b0, 32'h1234_5678, 32'd0, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if (dc !== 33) begin n_fail++; $display("FAIL divz_latency: done at cycle %0d, want 33", dc); end
        n_cmp++;
        if ({q, r} !== {32'hFFFF_FFFF, 32'h1234_5678}) begin
            n_fail++; $display("FAIL divu_zero: got q=%h r=%h, want q=ffffffff r=12345678", q, r);
        end
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if ({q, r} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin
            n_fail++; $display("FAIL div_zero_signed: got q=%h r=%h, want q=ffffffff r=fffffffb", q, r);
        end
    endtask

    task automatic test_cancel();
        int dc, ns, dcyc;
        logic sd, seen_done;
        logic [31:0] q, r;
        do_div(1'b0, 32'd77, 32'd5, 1'b0, dc, ns, sd, q, r);
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_div = 1'b1;
        opa = 32'hFFFF_FF9C;
        opb = 32'd7;
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        if (done) seen_done = 1'b1;
        n_cmp++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL cancel_stall_same_cycle: got %b, want 1", stall_req); end
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start = 1'b0;
        #1;
        n_cmp++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL cancel_stall_next: got %b, want 0", stall_req); end
        n_cmp++;
        if ({quotient, remainder} !== {32'd15, 32'd2}) begin
            n_fail++; $display("FAIL cancel_hold: got q=%0d r=%0d, want q=15 r=2", quotient, remainder);
        end
        start = 1'b1;
        signed_div = 1'b0;
        opa = 32'd9;
        opb = 32'd3;
        dcyc = -1;
        for (int c = 11; c < 60 && dcyc < 0; c++) begin
            @(negedge clk);
            if (done) begin
                dcyc = c;
                q = quotient;
                r = remainder;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_cmp++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: done pulse seen=%b, want 0", seen_done); end
        n_cmp++;
        if (dcyc !== 44) begin n_fail++; $display("FAIL cancel_restart_latency: done at cycle %0d, want 44", dcyc); end
        n_cmp++;
        if ({q, r} !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL cancel_restart_9_3: got q=%0d r=%0d, want q=3 r=0", q, r); end
    endtask

    task automatic test_back_to_back();
        int dc, ns, extra;
        logic sd;
        logic [31:0] q, r;
        do_div(1'b0, 32'd1000, 32'd10, 1'b0, dc, ns, sd, q, r);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || stall_req) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin n_fail++; $display("FAIL hold_no_restart: %0d cycles with done/stall, want 0", extra); end
        do_div(1'b1, 32'hFFFF_FC18, 32'd9, 1'b0, dc, ns, sd, q, r);
        do_div(1'b0, 32'd81, 32'd4, 1'b1, dc, ns, sd, q, r);
        n_cmp++;
        if (dc !== 33) begin n_fail++; $display("FAIL b2b_latency: done at cycle %0d, want 33", dc); end
        n_cmp++;
        if ({q, r} !== {32'd20, 32'd1}) begin n_fail++; $display("FAIL b2b_81_4: got q=%0d r=%0d, want q=20 r=1", q, r); end
    endtask

    task automatic test_reset_mid();
        int dc, ns;
        logic sd;
        logic [31:0] q, r;
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_div = 1'b0;
        opa = 32'h0000_FFFF;
        opb = 32'd3;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        n_cmp++;
        if ({stall_req, done, quotient, remainder} !== 66'd0) begin
            n_fail++; $display("FAIL reset_mid: got stall=%b done=%b q=%h r=%h, want all 0", stall_req, done, quotient, remainder);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        do_div(1'b0, 32'd50, 32'd5, 1'b0, dc, ns, sd, q, r);
        n_cmp++;
        if ({q, r, dc} !== {32'd10, 32'd0, 32'd33}) begin
            n_fail++; $display("FAIL reset_then_50_5: got q=%0d r=%0d cyc=%0d, want q=10 r=0 cyc=33", q, r, dc);
        end
    endtask

    task automatic test_random();
        int dc, ns;
        logic sd, s;
        logic [31:0] a, b, q, r;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = 32'd0 - $urandom_range(1, 255);
                default: b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF;
            endcase
            if (i == 5) a = 32'h8000_0000;
            exp = model(s, a, b);
            do_div(s, a, b, bit'($urandom_range(0, 1)), dc, ns, sd, q, r);
            n_cmp++;
            if ({r, q} !== exp || dc !== 33) begin
                n_fail++;
                $display("FAIL rand_%0d s=%b a=%h b=%h: got q=%h r=%h cyc=%0d, want q=%h r=%h cyc=33",
                         i, s, a, b, q, r, dc, exp[31:0], exp[63:32]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
